// File: rtl/mfp_ahb_uart_tx.sv
// Purpose: generic synchronous FIFO holding bytes queued for the UART serializer.
// Latency: head entry visible combinationally; push/pop take effect on the next HCLK edge.
// Backpressure: a push while full is ignored unless a pop happens on the same edge.
module mfp_ahb_uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [4:0]       count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == 5'(DEPTH));
    assign empty    = (count == 5'd0);
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    // Storage: written only on an accepted push; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Purpose: AHB-Lite slave UART transmitter (TXDATA/STATUS/DIVISOR) feeding an 8N1 serializer.
// Latency: zero bus wait states; UART_TX falls 2 HCLK edges after a TXDATA data phase when idle.
// Backpressure: none on the bus; TXDATA writes to a full FIFO are dropped and set STATUS.overflow.
module mfp_ahb_uart_tx #(
    parameter logic [15:0] CLK_DIV_RESET = 16'd434,
    parameter int          FIFO_DEPTH    = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic        UART_TX,
    output logic        TX_IRQ
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [1:0] A_TXDATA  = 2'd0;
    localparam logic [1:0] A_STATUS  = 2'd1;
    localparam logic [1:0] A_DIVISOR = 2'd2;

    // Registered address phase.
    logic        ap_vld;
    logic        ap_write;
    logic [1:0]  ap_addr;

    // Control/status registers.
    logic [15:0] divisor;
    logic        overflow;

    // Serializer state.
    state_t      state;
    logic [15:0] bit_len;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        tx_q;

    // FIFO interface.
    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [4:0]  fifo_count;

    logic        wr_txdata;
    logic        wr_status;
    logic        wr_divisor;
    logic        bit_end;
    logic        busy;
    logic [15:0] div_clamped;
    logic        unused_bits;

    // Only HADDR[3:2], HTRANS[1] and the low HWDATA bits carry meaning here.
    assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

    assign HREADY  = 1'b1;
    assign HRESP   = 1'b0;
    assign UART_TX = tx_q;

    assign wr_txdata  = ap_vld && ap_write && (ap_addr == A_TXDATA);
    assign wr_status  = ap_vld && ap_write && (ap_addr == A_STATUS);
    assign wr_divisor = ap_vld && ap_write && (ap_addr == A_DIVISOR);

    assign busy        = (state != ST_IDLE);
    assign bit_end     = (cnt == bit_len - 16'd1);
    // A divisor below 2 would make a bit shorter than the counter can express cleanly.
    assign div_clamped = (divisor < 16'd2) ? 16'd2 : divisor;
    assign TX_IRQ      = fifo_empty && (state == ST_IDLE);

    // The head is taken either from IDLE or at the very end of a stop bit (back-to-back).
    assign fifo_pop  = !fifo_empty &&
                       ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
    assign fifo_push = wr_txdata;

    mfp_ahb_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (HCLK),
        .rst      (HRESET),
        .push     (fifo_push),
        .push_dat (HWDATA[7:0]),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Capture the address phase; the data phase is the following cycle (HREADY is always 1).
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ap_vld   <= 1'b0;
            ap_write <= 1'b0;
            ap_addr  <= 2'd0;
        end else begin
            ap_vld   <= HSEL && HTRANS[1];
            ap_write <= HWRITE;
            ap_addr  <= HADDR[3:2];
        end
    end

    // Divisor register and sticky overflow flag, both updated at the end of a data phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            divisor  <= CLK_DIV_RESET;
            overflow <= 1'b0;
        end else begin
            if (wr_divisor) begin
                divisor <= HWDATA[15:0];
            end
            if (wr_status) begin
                overflow <= 1'b0;
            end else if (wr_txdata && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Read mux: only a valid read data phase returns anything non-zero.
    always_comb begin
        HRDATA = 32'd0;
        if (ap_vld && !ap_write && !HRESET) begin
            case (ap_addr)
                A_STATUS:  HRDATA = {23'd0, fifo_count, overflow, fifo_empty, fifo_full, busy};
                A_DIVISOR: HRDATA = {16'd0, divisor};
                default:   HRDATA = 32'd0;
            endcase
        end
    end

    // Transmit FSM; UART_TX is registered from the current state, so it lags the state by one edge.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= ST_IDLE;
            tx_q    <= 1'b1;
            bit_len <= 16'd2;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
        end else begin
            case (state)
                ST_START: tx_q <= 1'b0;
                ST_DATA:  tx_q <= shreg[0];
                default:  tx_q <= 1'b1;
            endcase

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state   <= ST_START;
                        shreg   <= fifo_head;
                        bit_len <= div_clamped;
                        cnt     <= 16'd0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state   <= ST_DATA;
                        cnt     <= 16'd0;
                        bit_idx <= 3'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt   <= 16'd0;
                        shreg <= shreg >> 1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cnt <= 16'd0;
                        if (!fifo_empty) begin
                            state   <= ST_START;
                            shreg   <= fifo_head;
                            bit_len <= div_clamped;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Purpose: self-checking bench for mfp_ahb_uart_tx; a line monitor checks every frame against a queue.
// Latency: bus tasks follow the AHB-Lite pipeline, one address phase then one data phase.
// Backpressure: none; the bench relies on HREADY being constant 1.
module tb_mfp_ahb_uart_tx;
    localparam logic [31:0] A_TXDATA  = 32'h0000_0000;
    localparam logic [31:0] A_STATUS  = 32'h0000_0004;
    localparam logic [31:0] A_DIVISOR = 32'h0000_0008;
    localparam logic [31:0] A_RSVD    = 32'h0000_000C;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        UART_TX;
    logic        TX_IRQ;

    typedef struct {
        logic [7:0] dat;
        int         len;
    } frame_t;

    frame_t exp_q[$];
    int     start_cyc[$];
    int     errors = 0;
    int     checks = 0;
    int     frames_done = 0;
    int     frames_started = 0;
    int     cyc = 0;
    int     bus_bad = 0;

    mfp_ahb_uart_tx #(
        .CLK_DIV_RESET (16'd434),
        .FIFO_DEPTH    (4)
    ) dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .HSEL    (HSEL),
        .HADDR   (HADDR),
        .HTRANS  (HTRANS),
        .HWRITE  (HWRITE),
        .HSIZE   (HSIZE),
        .HWDATA  (HWDATA),
        .HRDATA  (HRDATA),
        .HREADY  (HREADY),
        .HRESP   (HRESP),
        .UART_TX (UART_TX),
        .TX_IRQ  (TX_IRQ)
    );

    always #5 HCLK = ~HCLK;

    initial begin : cycle_counter
        forever begin
            @(posedge HCLK);
            cyc++;
        end
    end

    initial begin : bus_constants
        forever begin
            @(negedge HCLK);
            if (HREADY !== 1'b1 || HRESP !== 1'b0) bus_bad++;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion of all tests");
        $fatal(1, "watchdog");
    end

    // Line monitor: every start bit pops an expected frame and checks each of its cycles.
    initial begin : monitor
        logic       prev;
        logic       bad;
        logic       seen;
        logic       abort;
        logic [9:0] bits;
        frame_t     f;
        prev = 1'b1;
        forever begin
            @(negedge HCLK);
            if (HRESET === 1'b1) begin
                prev = 1'b1;
            end else if (prev === 1'b1 && UART_TX === 1'b0) begin
                frames_started++;
                start_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
                    prev = 1'b0;
                end else begin
                    f     = exp_q.pop_front();
                    bits  = {1'b1, f.dat, 1'b0};
                    abort = 1'b0;
                    for (int b = 0; b < 10 && !abort; b++) begin
                        bad  = 1'b0;
                        seen = bits[b];
                        for (int c = 0; c < f.len && !abort; c++) begin
                            if (b != 0 || c != 0) @(negedge HCLK);
                            if (HRESET === 1'b1) abort = 1'b1;
                            else if (UART_TX !== bits[b]) begin
                                bad  = 1'b1;
                                seen = UART_TX;
                            end
                        end
                        if (!abort) begin
                            checks++;
                            if (bad) begin
                                errors++;
                                $display("FAIL frame_bit: byte %h bit %0d len %0d saw %b, required %b",
                                         f.dat, b, f.len, seen, bits[b]);
                            end
                        end
                    end
                    if (!abort) frames_done++;
                    prev = 1'b1;
                end
            end else begin
                prev = UART_TX;
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic expect_frame(input logic [7:0] dat, input int len);
        frame_t f;
        f.dat = dat;
        f.len = len;
        exp_q.push_back(f);
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        tick();
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
        tick();
    endtask

    // Pipelined TXDATA writes: each data phase overlaps the next address phase.
    task automatic write_burst(input logic [7:0] d [8], input int n);
        for (int i = 0; i < n; i++) begin
            HSEL = 1'b1; HTRANS = (i == 0) ? 2'b10 : 2'b11; HWRITE = 1'b1; HADDR = A_TXDATA;
            if (i > 0) HWDATA = {24'd0, d[i-1]};
            tick();
        end
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = {24'd0, d[n-1]};
        tick();
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (frames_done < target && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (frames_done < target) begin
            errors++;
            $display("FAIL %s: frames done %0d, required %0d", name, frames_done, target);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int          fs;
        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HADDR = 32'd0; HWDATA = 32'd0; HSIZE = 3'b010;
        repeat (3) tick();
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b, required 1", UART_TX); end
        checks++; if (TX_IRQ !== 1'b1) begin errors++; $display("FAIL reset_tx_irq: got %b, required 1", TX_IRQ); end
        checks++; if (HRDATA !== 32'd0) begin errors++; $display("FAIL reset_hrdata: got %h, required 0", HRDATA); end
        HRESET = 1'b0;
        tick();
        ahb_read(A_STATUS, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL reset_status: got %h, required 00000004", d); end
        ahb_read(A_DIVISOR, d);
        checks++; if (d !== 32'd434) begin errors++; $display("FAIL reset_divisor: got %0d, required 434", d); end
        ahb_read(A_TXDATA, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL txdata_read: got %h, required 0", d); end
        ahb_write(A_RSVD, 32'hFFFF_FFFF);
        ahb_read(A_RSVD, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reserved_read: got %h, required 0", d); end
        ahb_read(A_DIVISOR, d);
        checks++; if (d !== 32'd434) begin errors++; $display("FAIL reserved_write_ignored: divisor %0d, required 434", d); end
        // TXDATA write whose data phase coincides with reset must vanish.
        fs = frames_started;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_TXDATA;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h12; HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        repeat (10) tick();
        ahb_read(A_STATUS, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL reset_data_phase_status: got %h, required 00000004", d); end
        checks++; if (frames_started !== fs) begin errors++; $display("FAIL reset_data_phase_frame: frames %0d, required %0d", frames_started, fs); end
    endtask

    task automatic test_single_byte();
        int base;
        ahb_write(A_DIVISOR, 32'd4);
        base = frames_done;
        expect_frame(8'h55, 4);
        ahb_write(A_TXDATA, 32'h55);
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL latency_edge0: got %b, required 1", UART_TX); end
        tick();
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL latency_edge1: got %b, required 1", UART_TX); end
        tick();
        checks++; if (UART_TX !== 1'b0) begin errors++; $display("FAIL latency_edge2: got %b, required 0", UART_TX); end
        checks++; if (TX_IRQ !== 1'b0) begin errors++; $display("FAIL irq_busy: got %b, required 0", TX_IRQ); end
        wait_frames(base + 1, 60, "single_frame_done");
        checks++; if (TX_IRQ !== 1'b1) begin errors++; $display("FAIL irq_after_frame: got %b, required 1", TX_IRQ); end
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL idle_after_frame: got %b, required 1", UART_TX); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [8];
        int         base;
        int         sbase;
        int         gap;
        ahb_write(A_DIVISOR, 32'd2);
        base  = frames_done;
        sbase = start_cyc.size();
        bytes[0] = 8'hA3; bytes[1] = 8'h0F;
        for (int i = 2; i < 8; i++) bytes[i] = 8'h00;
        expect_frame(8'hA3, 2);
        expect_frame(8'h0F, 2);
        write_burst(bytes, 2);
        wait_frames(base + 2, 80, "b2b_frames_done");
        gap = (start_cyc.size() >= sbase + 2) ? start_cyc[sbase+1] - start_cyc[sbase] : -1;
        checks++; if (gap !== 20) begin errors++; $display("FAIL b2b_gap: start spacing %0d cycles, required 20", gap); end
        checks++; if (TX_IRQ !== 1'b1) begin errors++; $display("FAIL b2b_irq: got %b, required 1", TX_IRQ); end
    endtask

    task automatic test_divisor_clamp();
        logic [31:0] d;
        int          base;
        int          sbase;
        int          gap;
        ahb_write(A_DIVISOR, 32'd0);
        base  = frames_done;
        sbase = start_cyc.size();
        expect_frame(8'hFF, 2);
        ahb_write(A_TXDATA, 32'hFF);
        ahb_write(A_DIVISOR, 32'd8);
        expect_frame(8'h81, 8);
        ahb_write(A_TXDATA, 32'h81);
        ahb_read(A_DIVISOR, d);
        checks++; if (d !== 32'd8) begin errors++; $display("FAIL divisor_readback: got %0d, required 8", d); end
        wait_frames(base + 2, 150, "clamp_frames_done");
        gap = (start_cyc.size() >= sbase + 2) ? start_cyc[sbase+1] - start_cyc[sbase] : -1;
        checks++; if (gap !== 20) begin errors++; $display("FAIL clamp_gap: start spacing %0d cycles, required 20", gap); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0]  bytes [8];
        logic [31:0] d;
        int          base;
        ahb_write(A_DIVISOR, 32'd2);
        base = frames_done;
        for (int i = 0; i < 8; i++) bytes[i] = 8'h10 + 8'(i);
        for (int i = 0; i < 6; i++) expect_frame(8'h10 + 8'(i), 2);
        write_burst(bytes, 5);
        // The next pop lands 17 edges after the last burst push; aim the sixth write's data phase there.
        repeat (15) tick();
        ahb_write(A_TXDATA, 32'h15);
        ahb_read(A_STATUS, d);
        checks++; if (d !== 32'h43) begin errors++; $display("FAIL full_push_pop_status: got %h, required 00000043", d); end
        wait_frames(base + 6, 200, "full_push_pop_frames");
        ahb_read(A_STATUS, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL full_push_pop_drained: got %h, required 00000004", d); end
    endtask

    task automatic test_overflow();
        logic [7:0]  bytes [8];
        logic [31:0] d;
        ahb_write(A_DIVISOR, 32'd1000);
        for (int i = 0; i < 8; i++) bytes[i] = 8'h20 + 8'(i);
        expect_frame(8'h20, 1000);
        write_burst(bytes, 6);
        ahb_read(A_STATUS, d);
        checks++; if (d !== 32'h4B) begin errors++; $display("FAIL overflow_status: got %h, required 0000004b", d); end
        ahb_write(A_STATUS, 32'h0);
        ahb_read(A_STATUS, d);
        checks++; if (d !== 32'h43) begin errors++; $display("FAIL overflow_clear: got %h, required 00000043", d); end
        HRESET = 1'b1;
        exp_q.delete();
        tick();
        tick();
        HRESET = 1'b0;
        tick();
        ahb_read(A_STATUS, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL overflow_reset_status: got %h, required 00000004", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0]  bytes [8];
        logic [31:0] d;
        int          fs;
        int          k;
        ahb_write(A_DIVISOR, 32'd8);
        fs = frames_started;
        bytes[0] = 8'h3C; bytes[1] = 8'hC3; bytes[2] = 8'h5A; bytes[3] = 8'hA5;
        for (int i = 4; i < 8; i++) bytes[i] = 8'h00;
        expect_frame(8'h3C, 8);
        write_burst(bytes, 4);
        k = 0;
        while (frames_started == fs && k < 20) begin
            tick();
            k++;
        end
        checks++; if (frames_started == fs) begin errors++; $display("FAIL midframe_start: frames started %0d, required %0d", frames_started, fs + 1); end
        repeat (24) tick();
        HRESET = 1'b1;
        exp_q.delete();
        tick();
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL midframe_reset_tx: got %b, required 1", UART_TX); end
        checks++; if (TX_IRQ !== 1'b1) begin errors++; $display("FAIL midframe_reset_irq: got %b, required 1", TX_IRQ); end
        HRESET = 1'b0;
        ahb_read(A_STATUS, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL midframe_status: got %h, required 00000004", d); end
        ahb_read(A_DIVISOR, d);
        checks++; if (d !== 32'd434) begin errors++; $display("FAIL midframe_divisor: got %0d, required 434", d); end
        fs = frames_started;
        repeat (200) tick();
        checks++; if (frames_started !== fs) begin errors++; $display("FAIL midframe_no_more_frames: frames %0d, required %0d", frames_started, fs); end
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL midframe_line_idle: got %b, required 1", UART_TX); end
    endtask

    task automatic test_bus_constants();
        checks++;
        if (bus_bad !== 0) begin
            errors++;
            $display("FAIL hready_hresp: %0d cycles with HREADY!=1 or HRESP!=0, required 0", bus_bad);
        end
    endtask

    initial begin : main
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_divisor_clamp();
        test_push_pop_full();
        test_overflow();
        test_reset_mid_frame();
        test_bus_constants();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_frames: %0d expected frames never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
